aximm_avmm_csr: RTL and testbench

Avalon-MM control/status register block for the AXI-MM GPIO PHY example. It sits directly downstream of the testbench/host AVMM port (`i_wr_addr`, `i_wrdata`, `i_wren`, `i_rden`) and upstream of the AXI-MM traffic generator/checker. It decodes the `0x5000_xxxx` register page, issues write/read burst start pulses, and holds delay settings. It returns link, bus and captured-data status with a sticky read-valid handshake.

---
 rtl/aximm_avmm_csr.sv | 213 +++++++++++++++++++++
 tb/tb_aximm_avmm_csr.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/aximm_avmm_csr.sv
// aximm_avmm_csr: Avalon-MM CSR page for the AXI-MM GPIO PHY traffic generator/checker.
// Decodes the PAGE register window, issues burst start pulses and returns status.
// Optional build macro: AXIMM_CSR_SNAPSHOT_EN (shadow 128-bit beats on word-0 reads).
module aximm_avmm_csr #(
    parameter logic [15:0] PAGE        = 16'h5000,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic          avmm_clk,
    input  logic          i_avmm_rst,
    input  logic [31:0]   i_wr_addr,
    input  logic [31:0]   i_wrdata,
    input  logic          i_wren,
    input  logic          i_rden,
    output logic [31:0]   o_master_readdata,
    output logic          o_master_readdatavalid,
    output logic          o_master_waitrequest,
    output logic          o_wr_start,
    output logic          o_rd_start,
    output logic [31:0]   o_mm_addr,
    output logic [31:0]   o_wr_cfg,
    output logic [31:0]   o_rd_cfg,
    output logic [15:0]   o_delay_x,
    output logic [15:0]   o_delay_y,
    output logic [15:0]   o_delay_z,
    input  logic          i_wr_done,
    input  logic          i_rd_done,
    input  logic [3:0]    i_linkup_sts,
    input  logic [3:0]    i_test_sts,
    input  logic [127:0]  i_dout_first,
    input  logic [127:0]  i_dout_last,
    input  logic [127:0]  i_din_first,
    input  logic [127:0]  i_din_last
);
    localparam int unsigned DW = 32;
    localparam int unsigned BW = 128;
    localparam int unsigned SW = 4;
    localparam int unsigned YW = 16;

    logic              wren_q, rden_q;
    logic [DW-1:0]     wr_cfg_q, wr_cfg_d, rd_cfg_q, rd_cfg_d, mm_addr_q, mm_addr_d;
    logic [YW-1:0]     dly_x_q, dly_x_d, dly_y_q, dly_y_d, dly_z_q, dly_z_d;
    logic              wr_done_q, wr_done_d, rd_done_q, rd_done_d;
    logic              wr_start_q, wr_start_d, rd_start_q, rd_start_d;
    logic              rd_pend_q, rd_pend_d, rvalid_q, rvalid_d, wait_q, wait_d;
    logic [DW-1:0]     rd_capt_q, rd_capt_d, rdata_q, rdata_d;
    logic [SYNC_STAGES*SW-1:0] link_sync_q, test_sync_q;
    logic [SW-1:0]     link_sts, test_sts;

    logic              page_hit, beat_hit, wr_edge, rd_edge, wr_hit;
    logic [15:0]       off;
    logic [1:0]        region, word;
    logic [BW-1:0]     live_beat, src_beat;
    logic [DW-1:0]     rd_mux;
    logic              unused_ok;

`ifdef AXIMM_CSR_SNAPSHOT_EN
    logic [BW-1:0]     shadow_q [4];
`endif

    assign unused_ok = ^i_wr_addr[1:0];
    assign link_sts  = link_sync_q[SYNC_STAGES*SW-1 -: SW];
    assign test_sts  = test_sync_q[SYNC_STAGES*SW-1 -: SW];

    // Address decode and strobe edge detection; a simultaneous write wins over a read.
    always_comb begin
        page_hit = (i_wr_addr[31:16] == PAGE);
        off      = {i_wr_addr[15:2], 2'b00};
        region   = off[5:4];
        word     = off[3:2];
        beat_hit = page_hit && (off[15:6] == 10'h100);
        wr_edge  = i_wren && !wren_q;
        rd_edge  = i_rden && !rden_q && !wr_edge;
        wr_hit   = wr_edge && page_hit;
    end

    // Read mux, evaluated against the current address at the read-detect edge.
    always_comb begin
        live_beat = i_dout_first;
        case (region)
            2'd0:    live_beat = i_dout_first;
            2'd1:    live_beat = i_dout_last;
            2'd2:    live_beat = i_din_first;
            default: live_beat = i_din_last;
        endcase
        src_beat = live_beat;
`ifdef AXIMM_CSR_SNAPSHOT_EN
        if (word != 2'd0) src_beat = shadow_q[region];
`endif
        rd_mux = '0;
        if (page_hit) begin
            case (off)
                16'h1000: rd_mux = {wr_cfg_q[31:3], 1'b0, wr_cfg_q[1:0]};
                16'h1004: rd_mux = mm_addr_q;
                16'h1008: rd_mux = {26'(0), rd_done_q, wr_done_q, test_sts};
                16'h100C: rd_mux = {28'(0), link_sts};
                16'h1010: rd_mux = {rd_cfg_q[31:3], 1'b0, rd_cfg_q[1:0]};
                16'h2000: rd_mux = {16'(0), dly_x_q};
                16'h2004: rd_mux = {16'(0), dly_y_q};
                16'h2008: rd_mux = {16'(0), dly_z_q};
                default: begin
                    if (beat_hit) begin
                        case (word)
                            2'd0:    rd_mux = src_beat[31:0];
                            2'd1:    rd_mux = src_beat[63:32];
                            2'd2:    rd_mux = src_beat[95:64];
                            default: rd_mux = src_beat[127:96];
                        endcase
                    end
                end
            endcase
        end
    end

    // Next state for registers, start pulses, sticky done bits and the read handshake.
    always_comb begin
        wr_cfg_d   = {wr_cfg_q[31:3], 1'b0, wr_cfg_q[1:0]};
        rd_cfg_d   = {rd_cfg_q[31:3], 1'b0, rd_cfg_q[1:0]};
        mm_addr_d  = mm_addr_q;
        dly_x_d    = dly_x_q;
        dly_y_d    = dly_y_q;
        dly_z_d    = dly_z_q;
        wr_start_d = 1'b0;
        rd_start_d = 1'b0;
        if (wr_hit) begin
            case (off)
                16'h1000: begin wr_cfg_d = i_wrdata; wr_start_d = i_wrdata[2]; end
                16'h1004: mm_addr_d = i_wrdata;
                16'h1010: begin rd_cfg_d = i_wrdata; rd_start_d = i_wrdata[2]; end
                16'h2000: dly_x_d = i_wrdata[15:0];
                16'h2004: dly_y_d = i_wrdata[15:0];
                16'h2008: dly_z_d = i_wrdata[15:0];
                default: ;
            endcase
        end
        // A start-bit write clears the sticky done bit even when the done pulse coincides.
        wr_done_d = wr_start_d ? 1'b0 : (wr_done_q || i_wr_done);
        rd_done_d = rd_start_d ? 1'b0 : (rd_done_q || i_rd_done);
        rd_pend_d = rd_edge;
        rd_capt_d = rd_edge ? rd_mux : rd_capt_q;
        wait_d    = rd_edge;
        rvalid_d  = rd_edge ? 1'b0 : (rd_pend_q ? 1'b1 : rvalid_q);
        rdata_d   = rd_pend_q ? rd_capt_q : rdata_q;
    end

    // State registers; strobe copies reset high so a strobe held through reset does not fire.
    always_ff @(posedge avmm_clk or posedge i_avmm_rst) begin
        if (i_avmm_rst) begin
            wren_q      <= 1'b1;
            rden_q      <= 1'b1;
            wr_cfg_q    <= '0;
            rd_cfg_q    <= '0;
            mm_addr_q   <= '0;
            dly_x_q     <= '0;
            dly_y_q     <= '0;
            dly_z_q     <= '0;
            wr_done_q   <= 1'b0;
            rd_done_q   <= 1'b0;
            wr_start_q  <= 1'b0;
            rd_start_q  <= 1'b0;
            rd_pend_q   <= 1'b0;
            rd_capt_q   <= '0;
            rdata_q     <= '0;
            rvalid_q    <= 1'b0;
            wait_q      <= 1'b1;
            link_sync_q <= '0;
            test_sync_q <= '0;
        end else begin
            wren_q      <= i_wren;
            rden_q      <= i_rden;
            wr_cfg_q    <= wr_cfg_d;
            rd_cfg_q    <= rd_cfg_d;
            mm_addr_q   <= mm_addr_d;
            dly_x_q     <= dly_x_d;
            dly_y_q     <= dly_y_d;
            dly_z_q     <= dly_z_d;
            wr_done_q   <= wr_done_d;
            rd_done_q   <= rd_done_d;
            wr_start_q  <= wr_start_d;
            rd_start_q  <= rd_start_d;
            rd_pend_q   <= rd_pend_d;
            rd_capt_q   <= rd_capt_d;
            rdata_q     <= rdata_d;
            rvalid_q    <= rvalid_d;
            wait_q      <= wait_d;
            link_sync_q <= {link_sync_q[(SYNC_STAGES-1)*SW-1:0], i_linkup_sts};
            test_sync_q <= {test_sync_q[(SYNC_STAGES-1)*SW-1:0], i_test_sts};
        end
    end

`ifdef AXIMM_CSR_SNAPSHOT_EN
    // Capture the whole beat on a word-0 read so words 1-3 come from the same instant.
    always_ff @(posedge avmm_clk or posedge i_avmm_rst) begin
        if (i_avmm_rst) begin
            for (int i = 0; i < 4; i++) shadow_q[i] <= '0;
        end else if (rd_edge && beat_hit && (word == 2'd0)) begin
            shadow_q[region] <= live_beat;
        end
    end
`endif

    assign o_master_readdata      = rdata_q;
    assign o_master_readdatavalid = rvalid_q;
    assign o_master_waitrequest   = wait_q;
    assign o_wr_start             = wr_start_q;
    assign o_rd_start             = rd_start_q;
    assign o_mm_addr              = mm_addr_q;
    assign o_wr_cfg               = wr_cfg_q;
    assign o_rd_cfg               = rd_cfg_q;
    assign o_delay_x              = dly_x_q;
    assign o_delay_y              = dly_y_q;
    assign o_delay_z              = dly_z_q;

endmodule

// File: tb/tb_aximm_avmm_csr.sv
// tb_aximm_avmm_csr: directed self-checking bench for the aximm_avmm_csr register page.
module tb_aximm_avmm_csr;
    logic         clk;
    logic         rst;
    logic [31:0]  wr_addr, wrdata;
    logic         wren, rden;
    logic [31:0]  readdata;
    logic         rvalid, waitreq, wr_start, rd_start;
    logic [31:0]  mm_addr, wr_cfg, rd_cfg;
    logic [15:0]  dly_x, dly_y, dly_z;
    logic         wr_done, rd_done;
    logic [3:0]   linkup, test_sts;
    logic [127:0] dout_first, dout_last, din_first, din_last;

    int n_checks = 0;
    int n_fail   = 0;
    int wr_pulses = 0;
    int rd_pulses = 0;
    logic [31:0] wr_cfg_at_pulse = '0;
    logic [31:0] last_rd = '0;

    typedef struct {
        bit          wr;
        logic [31:0] addr;
        logic [31:0] data;
        logic [31:0] exp;
    } vec_t;
    vec_t vecs[18];

    aximm_avmm_csr dut (
        .avmm_clk(clk), .i_avmm_rst(rst),
        .i_wr_addr(wr_addr), .i_wrdata(wrdata), .i_wren(wren), .i_rden(rden),
        .o_master_readdata(readdata), .o_master_readdatavalid(rvalid),
        .o_master_waitrequest(waitreq),
        .o_wr_start(wr_start), .o_rd_start(rd_start),
        .o_mm_addr(mm_addr), .o_wr_cfg(wr_cfg), .o_rd_cfg(rd_cfg),
        .o_delay_x(dly_x), .o_delay_y(dly_y), .o_delay_z(dly_z),
        .i_wr_done(wr_done), .i_rd_done(rd_done),
        .i_linkup_sts(linkup), .i_test_sts(test_sts),
        .i_dout_first(dout_first), .i_dout_last(dout_last),
        .i_din_first(din_first), .i_din_last(din_last)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Count start pulses one sample per cycle, so a stretched pulse counts more than once.
    always @(negedge clk) begin
        if (wr_start) begin wr_pulses++; wr_cfg_at_pulse = wr_cfg; end
        if (rd_start) rd_pulses++;
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Called at a negedge; returns at a negedge with both strobes low.
    task automatic do_write(input logic [31:0] a, input logic [31:0] d, input int hold);
        wr_addr = a; wrdata = d; wren = 1'b1;
        repeat (hold) @(negedge clk);
        wren = 1'b0;
        @(negedge clk);
    endtask

    task automatic do_read(input logic [31:0] a, input string nm, input logic [31:0] exp);
        wr_addr = a; rden = 1'b1;
        @(negedge clk);
        chk({nm, "_wait_at_detect"}, {31'b0, waitreq}, 32'd1);
        chk({nm, "_valid_at_detect"}, {31'b0, rvalid}, 32'd0);
        @(negedge clk);
        chk({nm, "_valid"}, {31'b0, rvalid}, 32'd1);
        chk({nm, "_wait"}, {31'b0, waitreq}, 32'd0);
        chk({nm, "_data"}, readdata, exp);
        last_rd = readdata;
        rden = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        rst = 1'b1; wr_addr = '0; wrdata = '0; wren = 1'b0; rden = 1'b0;
        wr_done = 1'b0; rd_done = 1'b0; linkup = '0; test_sts = '0;
        dout_first = '0; dout_last = '0; din_first = '0; din_last = '0;

        vecs[0]  = '{1'b1, 32'h5000_2008, 32'h0000_1770, 32'h0};
        vecs[1]  = '{1'b0, 32'h5000_2008, 32'h0,         32'h0000_1770};
        vecs[2]  = '{1'b1, 32'h5000_2000, 32'hABCD_1234, 32'h0};
        vecs[3]  = '{1'b0, 32'h5000_2000, 32'h0,         32'h0000_1234};
        vecs[4]  = '{1'b1, 32'h5000_2004, 32'hFFFF_FFFF, 32'h0};
        vecs[5]  = '{1'b0, 32'h5000_2004, 32'h0,         32'h0000_FFFF};
        vecs[6]  = '{1'b1, 32'h5000_1004, 32'hDEAD_BEEF, 32'h0};
        vecs[7]  = '{1'b0, 32'h5000_1004, 32'h0,         32'hDEAD_BEEF};
        vecs[8]  = '{1'b1, 32'h5000_1010, 32'h0000_00F3, 32'h0};
        vecs[9]  = '{1'b0, 32'h5000_1010, 32'h0,         32'h0000_00F3};
        vecs[10] = '{1'b1, 32'h5000_1007, 32'h1234_5678, 32'h0};
        vecs[11] = '{1'b0, 32'h5000_1006, 32'h0,         32'h1234_5678};
        vecs[12] = '{1'b1, 32'h6000_1004, 32'hFFFF_FFFF, 32'h0};
        vecs[13] = '{1'b0, 32'h5000_1004, 32'h0,         32'h1234_5678};
        vecs[14] = '{1'b0, 32'h6000_0000, 32'h0,         32'h0};
        vecs[15] = '{1'b1, 32'h5000_1008, 32'hFFFF_FFFF, 32'h0};
        vecs[16] = '{1'b0, 32'h5000_1008, 32'h0,         32'h0};
        vecs[17] = '{1'b0, 32'h5000_3000, 32'h0,         32'h0};

        // Reset state and release.
        repeat (3) @(negedge clk);
        chk("rst_wait", {31'b0, waitreq}, 32'd1);
        chk("rst_valid", {31'b0, rvalid}, 32'd0);
        chk("rst_delay_z", {16'b0, dly_z}, 32'd0);
        chk("rst_wr_cfg", wr_cfg, 32'd0);
        rst = 1'b0;
        #1 chk("rel_wait_hold", {31'b0, waitreq}, 32'd1);
        @(negedge clk);
        chk("rel_wait_fall", {31'b0, waitreq}, 32'd0);
        chk("rel_valid", {31'b0, rvalid}, 32'd0);

        // Table of register writes and readbacks.
        for (int i = 0; i < 18; i++) begin
            if (vecs[i].wr) do_write(vecs[i].addr, vecs[i].data, 1);
            else            do_read(vecs[i].addr, $sformatf("vec%0d", i), vecs[i].exp);
        end
        chk("delay_z_6000", {16'b0, dly_z}, 32'd6000);
        chk("delay_x", {16'b0, dly_x}, 32'h0000_1234);
        chk("mm_addr_out", mm_addr, 32'h1234_5678);
        chk("no_start_pulses", wr_pulses + rd_pulses, 32'd0);

        // Write start with strobe held 6 cycles: exactly one pulse.
        do_write(32'h5000_1000, 32'h0004_1804, 6);
        repeat (3) @(negedge clk);
        chk("wr_start_count", wr_pulses, 32'd1);
        chk("wr_cfg_at_pulse", wr_cfg_at_pulse, 32'h0004_1804);
        chk("wr_cfg_selfclr", wr_cfg, 32'h0004_1800);
        do_read(32'h5000_1000, "wr_cfg_rb", 32'h0004_1800);
        wr_done = 1'b1; @(negedge clk); wr_done = 1'b0; @(negedge clk);
        do_read(32'h5000_1008, "bus_wr_done", 32'h0000_0010);

        // Read start and sticky rd_done.
        do_write(32'h5000_1010, 32'h0000_0005, 1);
        chk("rd_start_count", rd_pulses, 32'd1);
        do_read(32'h5000_1010, "rd_cfg_rb", 32'h0000_0001);
        rd_done = 1'b1; @(negedge clk); rd_done = 1'b0; @(negedge clk);
        do_read(32'h5000_1008, "bus_both_done", 32'h0000_0030);

        // Clear and set of wr_done in the same cycle: clear wins.
        wr_done = 1'b1; wr_addr = 32'h5000_1000; wrdata = 32'h0000_0004; wren = 1'b1;
        @(negedge clk);
        wr_done = 1'b0; wren = 1'b0;
        @(negedge clk);
        chk("wr_start_count2", wr_pulses, 32'd2);
        do_read(32'h5000_1008, "bus_clear_wins", 32'h0000_0020);

        // Synchronised link and test status.
        linkup = 4'hF;
        repeat (3) @(negedge clk);
        do_read(32'h5000_100C, "link_f", 32'h0000_000F);
        linkup = 4'h5;
        do_read(32'h5000_100C, "link_not_yet", 32'h0000_000F);
        repeat (3) @(negedge clk);
        do_read(32'h5000_100C, "link_5", 32'h0000_0005);
        test_sts = 4'b1111;
        repeat (3) @(negedge clk);
        do_read(32'h5000_1008, "bus_test_sts", 32'h0000_002F);

        // Captured beats: word 0 then later words after the input changes.
        dout_first = {32'h4444_4444, 32'h3333_3333, 32'h2222_2222, 32'h1111_1111};
        @(negedge clk);
        do_read(32'h5000_4000, "dout_first_w0", 32'h1111_1111);
        dout_first = {32'h8888_8888, 32'h7777_7777, 32'h6666_6666, 32'h5555_5555};
        @(negedge clk);
`ifdef AXIMM_CSR_SNAPSHOT_EN
        do_read(32'h5000_4004, "dout_first_w1", 32'h2222_2222);
        do_read(32'h5000_400C, "dout_first_w3", 32'h4444_4444);
`else
        do_read(32'h5000_4004, "dout_first_w1", 32'h6666_6666);
        do_read(32'h5000_400C, "dout_first_w3", 32'h8888_8888);
`endif
        dout_last = {32'hA3A3_A3A3, 32'hA2A2_A2A2, 32'hA1A1_A1A1, 32'hA0A0_A0A0};
        din_first = {32'hB3B3_B3B3, 32'hB2B2_B2B2, 32'hB1B1_B1B1, 32'hB0B0_B0B0};
        din_last  = {32'hC3C3_C3C3, 32'hC2C2_C2C2, 32'hC1C1_C1C1, 32'hC0C0_C0C0};
        @(negedge clk);
        do_read(32'h5000_4010, "dout_last_w0", 32'hA0A0_A0A0);
        do_read(32'h5000_401C, "dout_last_w3", 32'hA3A3_A3A3);
        do_read(32'h5000_4020, "din_first_w0", 32'hB0B0_B0B0);
        do_read(32'h5000_4028, "din_first_w2", 32'hB2B2_B2B2);
        do_read(32'h5000_4030, "din_last_w0", 32'hC0C0_C0C0);
        do_read(32'h5000_4034, "din_last_w1", 32'hC1C1_C1C1);

        // Both strobes rise together: write happens, no read completes.
        wr_addr = 32'h5000_2000; wrdata = 32'h0000_0BAD; wren = 1'b1; rden = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk($sformatf("both_wait_c%0d", i), {31'b0, waitreq}, 32'd0);
            chk($sformatf("both_valid_c%0d", i), {31'b0, rvalid}, 32'd1);
            chk($sformatf("both_data_c%0d", i), readdata, 32'hC1C1_C1C1);
        end
        wren = 1'b0; rden = 1'b0;
        @(negedge clk);
        chk("both_delay_x", {16'b0, dly_x}, 32'h0000_0BAD);
        do_read(32'h5000_2000, "both_rb", 32'h0000_0BAD);

        // Write edge one cycle after a read edge does not disturb the read.
        wr_addr = 32'h5000_2004; rden = 1'b1;
        @(negedge clk);
        chk("wdr_wait", {31'b0, waitreq}, 32'd1);
        wrdata = 32'h0000_1111; wren = 1'b1;
        @(negedge clk);
        chk("wdr_valid", {31'b0, rvalid}, 32'd1);
        chk("wdr_data", readdata, 32'h0000_FFFF);
        wren = 1'b0; rden = 1'b0;
        @(negedge clk);
        do_read(32'h5000_2004, "wdr_rb", 32'h0000_1111);

        // Reset one cycle after a read edge, with the strobe held through release.
        wr_addr = 32'h5000_1004; rden = 1'b1;
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk("mrst_valid", {31'b0, rvalid}, 32'd0);
        chk("mrst_wait", {31'b0, waitreq}, 32'd1);
        @(negedge clk);
        chk("mrst_wait_hold", {31'b0, waitreq}, 32'd1);
        rst = 1'b0;
        #1 chk("mrst_wait_rel", {31'b0, waitreq}, 32'd1);
        @(negedge clk);
        chk("mrst_wait_fall", {31'b0, waitreq}, 32'd0);
        chk("mrst_valid_low", {31'b0, rvalid}, 32'd0);
        @(negedge clk);
        chk("mrst_no_read_wait", {31'b0, waitreq}, 32'd0);
        chk("mrst_no_read_valid", {31'b0, rvalid}, 32'd0);
        rden = 1'b0;
        @(negedge clk);
        chk("mrst_mm_addr", mm_addr, 32'd0);
        do_read(32'h5000_2008, "mrst_delay_z", 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
